// File: rtl/mcpu_pkg.sv
// Shared encodings for the mcpu core: stage codes,
// opcode class/sub fields, HLT value and decode helper.
package mcpu_pkg;

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_FETCHA = 3'd1;
  localparam logic [2:0] S_FETCHB = 3'd2;
  localparam logic [2:0] S_EXECA  = 3'd3;
  localparam logic [2:0] S_EXECB  = 3'd4;

  localparam logic [2:0] C_MEM = 3'b000;
  localparam logic [2:0] C_JMP = 3'b001;
  localparam logic [2:0] C_LDI = 3'b010;
  localparam logic [2:0] C_ALU = 3'b100;

  localparam logic [1:0] M_LD = 2'b01;
  localparam logic [1:0] M_ST = 2'b10;

  localparam logic [1:0] J_C   = 2'b00;
  localparam logic [1:0] J_NC  = 2'b01;
  localparam logic [1:0] J_Z   = 2'b10;
  localparam logic [1:0] J_MP  = 2'b11;

  localparam logic [1:0] A_ADD = 2'b00;
  localparam logic [1:0] A_SUB = 2'b01;
  localparam logic [1:0] A_AND = 2'b10;
  localparam logic [1:0] A_OR  = 2'b11;

  localparam logic [7:0] OP_HLT = 8'hFF;

  typedef struct packed {
    logic       ld;
    logic       st;
    logic       jmp;
    logic       ldi;
    logic       alu;
    logic       hlt;
    logic [1:0] sub;
  } dec_t;

  // Anything not matched here is a NOP.
  function automatic dec_t decode(input logic [7:0] op);
    dec_t d;
    d     = '0;
    d.sub = op[4:3];
    unique case (1'b1)
      op == OP_HLT:
        d.hlt = 1'b1;
      op[7:5] == C_MEM && op[4:3] == M_LD:
        d.ld = 1'b1;
      op[7:5] == C_MEM && op[4:3] == M_ST:
        d.st = 1'b1;
      op[7:5] == C_JMP:
        d.jmp = 1'b1;
      op[7:5] == C_LDI:
        d.ldi = 1'b1;
      op[7:5] == C_ALU:
        d.alu = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mcpu_regfile.sv
// mcpu register file: NREG x DW, two async read ports,
// one sync write port (we/wa/wd), async active-high reset.
module mcpu_regfile
  import mcpu_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int RIW  = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [RIW-1:0] ra_addr,
  output logic [DW-1:0]  ra_data,
  input  logic [RIW-1:0] rb_addr,
  output logic [DW-1:0]  rb_data,
  input  logic           we,
  input  logic [RIW-1:0] wa,
  input  logic [DW-1:0]  wd
);

  logic [DW-1:0] regs [NREG];

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

endmodule

// File: rtl/mcpu.sv
// mcpu top: 4-stage multicycle CPU (fetch A/B, exec A/B).
// Ports: clk, rst, run/halt, mem_* bus, one-hot stage
// outputs, cflag/zflag, pc. Define MCPU_READY_EN to honour
// mem_ready wait states; otherwise mem_ready is ignored.
module mcpu
  import mcpu_pkg::*;
#(
  parameter int DW   = 8,
  parameter int AW   = 8,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          halt,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_rden,
  output logic          mem_wren,
  input  logic          mem_ready,
  output logic          waits,
  output logic          fetcha,
  output logic          fetchb,
  output logic          execa,
  output logic          execb,
  output logic          cflag,
  output logic          zflag,
  output logic [AW-1:0] pc
);

  localparam int RIW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [2:0]    stage;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] ira;
  logic [DW-1:0] irb;
  logic [DW-1:0] tmp;
  logic          cf;
  logic          zf;
  dec_t          dec;
  logic          rdy;

`ifdef MCPU_READY_EN
  assign rdy = mem_ready;
`else
  logic unused_ready;
  assign unused_ready = mem_ready;
  assign rdy = 1'b1;
`endif

  if (DW > 8) begin : g_wide
    logic unused_ira_hi;
    assign unused_ira_hi = ^ira[DW-1:8];
  end

  assign dec = decode(ira[7:0]);

  logic [RIW-1:0] rd_idx;
  logic [RIW-1:0] rs_idx;
  logic [DW-1:0]  rd_data;
  logic [DW-1:0]  rs_data;
  logic           rf_we;
  logic [DW-1:0]  rf_wd;

  assign rd_idx = ira[RIW-1:0];
  assign rs_idx = irb[RIW-1:0];

  mcpu_regfile #(
    .DW  (DW),
    .NREG(NREG),
    .RIW (RIW)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .ra_addr(rd_idx),
    .ra_data(rd_data),
    .rb_addr(rs_idx),
    .rb_data(rs_data),
    .we     (rf_we),
    .wa     (rd_idx),
    .wd     (rf_wd)
  );

  // Extra top bit holds carry (ADD) or borrow (SUB).
  logic [DW-1:0] alu_r;
  logic          alu_c;

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    unique case (dec.sub)
      A_ADD: {alu_c, alu_r} = {1'b0, rd_data} + {1'b0, rs_data};
      A_SUB: {alu_c, alu_r} = {1'b0, rd_data} - {1'b0, rs_data};
      A_AND: alu_r = rd_data & rs_data;
      A_OR:  alu_r = rd_data | rs_data;
    endcase
  end

  logic take;

  always_comb begin
    take = 1'b0;
    unique case (dec.sub)
      J_C:  take = cf;
      J_NC: take = !cf;
      J_Z:  take = zf;
      J_MP: take = 1'b1;
    endcase
  end

  logic is_fetch;
  logic in_exa;
  logic mem_op;

  assign is_fetch = (stage == S_FETCHA) || (stage == S_FETCHB);
  assign in_exa   = (stage == S_EXECA);
  assign mem_op   = dec.ld || dec.st;

  assign mem_rden  = is_fetch || (in_exa && dec.ld);
  assign mem_wren  = in_exa && dec.st;
  assign mem_addr  = is_fetch ? pc_q :
                     (in_exa && mem_op) ? irb[AW-1:0] : '0;
  assign mem_wdata = mem_wren ? rd_data : '0;

  assign rf_we = (stage == S_EXECB) &&
                 (dec.ld || dec.ldi || dec.alu);
  assign rf_wd = dec.ldi ? irb : tmp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= S_WAIT;
      pc_q  <= '0;
      ira   <= '0;
      irb   <= '0;
      tmp   <= '0;
      cf    <= 1'b0;
      zf    <= 1'b0;
    end else begin
      case (stage)
        S_WAIT: begin
          if (run && !halt) stage <= S_FETCHA;
        end
        S_FETCHA: begin
          if (rdy) begin
            ira   <= mem_rdata;
            pc_q  <= pc_q + AW'(1);
            stage <= S_FETCHB;
          end
        end
        S_FETCHB: begin
          if (rdy) begin
            irb   <= mem_rdata;
            pc_q  <= pc_q + AW'(1);
            stage <= S_EXECA;
          end
        end
        S_EXECA: begin
          if (!mem_op || rdy) stage <= S_EXECB;
          if (dec.ld && rdy) tmp <= mem_rdata;
          if (dec.alu) begin
            tmp <= alu_r;
            cf  <= alu_c;
            zf  <= (alu_r == '0);
          end
          if (dec.jmp && take) pc_q <= irb[AW-1:0];
        end
        S_EXECB: begin
          stage <= (halt || dec.hlt) ? S_WAIT : S_FETCHA;
        end
        default: stage <= S_WAIT;
      endcase
    end
  end

  assign waits  = (stage == S_WAIT);
  assign fetcha = (stage == S_FETCHA);
  assign fetchb = (stage == S_FETCHB);
  assign execa  = (stage == S_EXECA);
  assign execb  = (stage == S_EXECB);
  assign cflag  = cf;
  assign zflag  = zf;
  assign pc     = pc_q;

endmodule

// File: tb/tb_mcpu.sv
// Scoreboard bench for mcpu: ISA-level reference model
// predicts memory writes, pc and flags for each program.
module tb_mcpu;

`ifdef MCPU_READY_EN
  localparam bit RDY_EN = 1'b1;
`else
  localparam bit RDY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic       halt = 1'b0;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_rden;
  logic       mem_wren;
  logic       mem_ready;
  logic       waits, fetcha, fetchb, execa, execb;
  logic       cflag, zflag;
  logic [7:0] pc;

  int total = 0;
  int bad = 0;

  // init_mem is owned by the stimulus, wmem/wgen by the bus.
  logic [7:0] init_mem [256];
  logic [7:0] wmem [256];
  int         wgen [256];
  int         gen = 1;

  logic rand_ready = 1'b0;
  logic ready_val = 1'b1;
  logic rnd_bit = 1'b1;

  assign mem_ready = rand_ready ? rnd_bit : ready_val;
  assign mem_rdata = (wgen[mem_addr] == gen) ?
                     wmem[mem_addr] : init_mem[mem_addr];

  always #5 clk = ~clk;

  mcpu dut (
    .clk(clk), .rst(rst), .run(run), .halt(halt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rden(mem_rden),
    .mem_wren(mem_wren), .mem_ready(mem_ready),
    .waits(waits), .fetcha(fetcha), .fetchb(fetchb),
    .execa(execa), .execb(execb),
    .cflag(cflag), .zflag(zflag), .pc(pc)
  );

  always @(posedge clk) rnd_bit <= ($urandom_range(0, 2) != 0);

  always @(posedge clk) begin
    if (mem_wren && (mem_ready || !RDY_EN)) begin
      wmem[mem_addr] <= mem_wdata;
      wgen[mem_addr] <= gen;
    end
  end

  function automatic logic [7:0] rd_mem(input logic [7:0] a);
    return (wgen[a] == gen) ? wmem[a] : init_mem[a];
  endfunction

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];

  // Monitor: bus sanity every cycle, write scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if ($countones({waits, fetcha, fetchb, execa, execb}) != 1 ||
          (mem_rden && mem_wren) ||
          (!mem_wren && mem_wdata != 8'h00)) begin
        bad++;
        $display("FAIL bus_sanity stage=%b rd=%b wr=%b wdata=%h",
                 {waits, fetcha, fetchb, execa, execb},
                 mem_rden, mem_wren, mem_wdata);
      end
      if (mem_wren && (mem_ready || !RDY_EN)) begin
        wr_t e;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write addr=%h data=%h",
                   mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if (e.a !== mem_addr || e.d !== mem_wdata) begin
            bad++;
            $display("FAIL st_write got %h:%h want %h:%h",
                     mem_addr, mem_wdata, e.a, e.d);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: instruction-level interpreter.
  logic [7:0] mm [256];
  logic [7:0] mr [8];
  logic       mc, mz;
  logic [7:0] mpc;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mm[i] = init_mem[i];
    for (int i = 0; i < 8; i++) mr[i] = 8'h00;
    mc = 1'b0;
    mz = 1'b0;
    mpc = 8'h00;
  endtask

  task automatic model_run();
    int steps;
    bit done;
    steps = 0;
    done = 0;
    while (!done && steps < 1000) begin
      logic [7:0] a, b;
      int cls, sub, rd, rs, x, y, s;
      bit tk;
      a = mm[mpc]; mpc = mpc + 8'd1;
      b = mm[mpc]; mpc = mpc + 8'd1;
      steps++;
      cls = int'(a) / 32;
      sub = (int'(a) / 8) % 4;
      rd = int'(a) % 8;
      rs = int'(b) % 8;
      x = int'(mr[rd]);
      y = int'(mr[rs]);
      if (a == 8'hFF) begin
        done = 1;
      end else if (cls == 0 && sub == 1) begin
        mr[rd] = mm[b];
      end else if (cls == 0 && sub == 2) begin
        mm[b] = mr[rd];
        exp_q.push_back({b, mr[rd]});
      end else if (cls == 1) begin
        tk = (sub == 3) || (sub == 0 && mc) ||
             (sub == 1 && !mc) || (sub == 2 && mz);
        if (tk) mpc = b;
      end else if (cls == 2) begin
        mr[rd] = b;
      end else if (cls == 4) begin
        case (sub)
          0: begin s = x + y; mc = (s > 255); end
          1: begin s = x - y; mc = (x < y); end
          2: begin s = x & y; mc = 1'b0; end
          default: begin s = x | y; mc = 1'b0; end
        endcase
        s = s & 255;
        mz = (s == 0);
        mr[rd] = 8'(s);
      end
    end
  endtask

  task automatic clr_mem();
    gen++;
    for (int i = 0; i < 256; i++) init_mem[i] = 8'h00;
  endtask

  task automatic put(input int ad, input logic [7:0] a,
                     input logic [7:0] b);
    init_mem[ad] = a;
    init_mem[ad+1] = b;
  endtask

  task automatic gen_prog(input int n);
    int p;
    logic [7:0] a, b;
    p = 0;
    for (int i = 128; i < 256; i++) init_mem[i] = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      case ($urandom_range(0, 5))
        0: a = {3'b010, 5'($urandom)};
        1: a = {3'b100, 5'($urandom)};
        2: begin
          a = {5'b00001, 3'($urandom)};
          b = 8'($urandom_range(128, 255));
        end
        3: begin
          a = {5'b00010, 3'($urandom)};
          b = 8'($urandom_range(128, 239));
        end
        4: begin
          a = {3'b001, 5'($urandom)};
          b = 8'(p + 4);
        end
        default: a = ($urandom_range(0, 1) == 1) ?
                     {3'b011, 5'($urandom)} : 8'h18;
      endcase
      put(p, a, b);
      p += 2;
    end
    for (int r = 0; r < 8; r++) begin
      put(p, {5'b00010, 3'(r)}, 8'(8'hF0 + r));
      p += 2;
    end
    put(p, 8'hFF, 8'h00);
  endtask

  task automatic do_reset();
    run = 1'b0;
    halt = 1'b0;
    ready_val = 1'b1;
    rand_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while (!waits && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!waits) begin
      bad++;
      $display("FAIL %s timeout waits=%b want 1", nm, waits);
    end
  endtask

  task automatic end_check(input string nm);
    chk({nm, "_pc"}, 32'(pc), 32'(mpc));
    chk({nm, "_cflag"}, 32'(cflag), 32'(mc));
    chk({nm, "_zflag"}, 32'(zflag), 32'(mz));
    chk({nm, "_qempty"}, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  initial begin
    // Reset state, observed while rst is still high.
    #2 rst = 1'b1;
    #1;
    chk("rst_waits", 32'(waits), 1);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_flags", 32'({cflag, zflag}), 0);
    chk("rst_bus", 32'({mem_rden, mem_wren, mem_addr}), 0);
    do_reset();

    // LDI r1,5; LDI r2,3; ADD r1,r2; HLT; then ST r1.
    clr_mem();
    put(0, 8'h41, 8'h05);
    put(2, 8'h42, 8'h03);
    put(4, 8'h81, 8'h02);
    put(6, 8'hFF, 8'h00);
    put(8, 8'h11, 8'hF0);
    put(10, 8'hFF, 8'h00);
    model_reset();
    model_run();
    do_reset();
    start();
    repeat (15) @(negedge clk);
    chk("add_busy_15", 32'(waits), 0);
    @(negedge clk);
    chk("add_idle_16", 32'(waits), 1);
    chk("add_flags", 32'({cflag, zflag}), 0);
    end_check("add_run1");
    model_run();
    start();
    wait_idle("add_run2", 200);
    chk("add_r1", 32'(rd_mem(8'hF0)), 8);
    end_check("add_run2");

    // Carry wrap to zero, then JC taken.
    clr_mem();
    put(0, 8'h40, 8'hFF);
    put(2, 8'h41, 8'h01);
    put(4, 8'h80, 8'h01);
    put(6, 8'h20, 8'h40);
    put(8'h40, 8'h10, 8'hF1);
    put(8'h42, 8'hFF, 8'h00);
    model_reset();
    model_run();
    do_reset();
    start();
    repeat (16) @(negedge clk);
    chk("jc_pc", 32'(pc), 32'h40);
    chk("jc_flags", 32'({cflag, zflag}), 32'b11);
    wait_idle("jc", 200);
    chk("jc_r0", 32'(rd_mem(8'hF1)), 0);
    end_check("jc");

    // ST r3 then LD r4 back through memory.
    clr_mem();
    put(0, 8'h43, 8'hA5);
    put(2, 8'h13, 8'h80);
    put(4, 8'h0C, 8'h80);
    put(6, 8'h14, 8'hF2);
    put(8, 8'hFF, 8'h00);
    model_reset();
    model_run();
    do_reset();
    start();
    wait_idle("stld", 200);
    chk("stld_mem80", 32'(rd_mem(8'h80)), 32'hA5);
    chk("stld_r4", 32'(rd_mem(8'hF2)), 32'hA5);
    end_check("stld");

`ifdef MCPU_READY_EN
    // Three wait states in FETCHA.
    clr_mem();
    put(0, 8'h40, 8'h01);
    put(2, 8'h10, 8'hF4);
    put(4, 8'hFF, 8'h00);
    model_reset();
    model_run();
    do_reset();
    ready_val = 1'b0;
    start();
    for (int i = 0; i < 3; i++) begin
      chk("ws_hold", 32'({fetcha, mem_rden, mem_addr, pc}),
          32'({1'b1, 1'b1, 8'h00, 8'h00}));
      @(negedge clk);
    end
    ready_val = 1'b1;
    @(negedge clk);
    chk("ws_fetchb", 32'({fetchb, pc}), 32'({1'b1, 8'h01}));
    repeat (3) @(negedge clk);
    chk("ws_7cyc", 32'({fetcha, pc}), 32'({1'b1, 8'h02}));
    wait_idle("ws", 200);
    end_check("ws");
`endif

    // halt during FETCHB, then run+halt in WAIT.
    clr_mem();
    put(0, 8'h45, 8'h07);
    put(2, 8'h15, 8'hF3);
    put(4, 8'hFF, 8'h00);
    model_reset();
    model_run();
    do_reset();
    start();
    for (int i = 0; i < 20 && !fetchb; i++) @(negedge clk);
    chk("hlt_saw_fetchb", 32'(fetchb), 1);
    halt = 1'b1;
    wait_idle("hlt_stop", 50);
    chk("hlt_pc", 32'(pc), 2);
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hlt_hold", 32'(waits), 1);
    end
    run = 1'b0;
    halt = 1'b0;
    start();
    wait_idle("hlt_resume", 200);
    chk("hlt_r5", 32'(rd_mem(8'hF3)), 7);
    end_check("hlt");

    // Reset in the middle of a stalled store.
    clr_mem();
    put(0, 8'h43, 8'hA5);
    put(2, 8'h13, 8'h80);
    put(4, 8'hFF, 8'h00);
    init_mem[8'h80] = 8'h11;
    do_reset();
    start();
    for (int i = 0; i < 20 && !(execa && mem_wren); i++)
      @(negedge clk);
    chk("rst_st_seen", 32'({execa, mem_wren}), 32'b11);
    ready_val = 1'b0;
    if (RDY_EN) begin
      @(negedge clk);
      chk("rst_st_stall", 32'({execa, mem_wren}), 32'b11);
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_wren", 32'(mem_wren), 0);
    chk("rst_mid_state", 32'({waits, pc, cflag, zflag}),
        32'({1'b1, 8'h00, 2'b00}));
    chk("rst_mid_bus", 32'({mem_rden, mem_addr, mem_wdata}), 0);
    @(negedge clk);
    rst = 1'b0;
    ready_val = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_retry", 32'({waits, mem_wren}), 32'b10);
    chk("rst_mem80", 32'(rd_mem(8'h80)), 32'h11);
    exp_q.delete();

    // Random programs against the reference model.
    for (int t = 0; t < 4; t++) begin
      clr_mem();
      gen_prog(30);
      model_reset();
      model_run();
      do_reset();
      rand_ready = RDY_EN;
      start();
      wait_idle("rand", 5000);
      rand_ready = 1'b0;
      end_check("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcpu.md
MCPU -- requirements
Module: mcpu

Interface
REQ-001 SHALL have parameter DW, default 8: data/register width, minimum 8.
REQ-002 SHALL have parameter AW, default 8: memory address width, 4..DW.
REQ-003 SHALL have parameter NREG, default 8: register count, one of 2, 4 or 8.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have ports run and halt, input, 1 bit each: start and stop requests.
REQ-007 SHALL have memory ports: mem_addr output AW; mem_wdata output DW; mem_rdata input DW; mem_rden output 1; mem_wren output 1; mem_ready input 1.
REQ-008 SHALL have outputs waits, fetcha, fetchb, execa, execb, 1 bit each: one-hot stage indication.
REQ-009 SHALL have outputs cflag and zflag (1 bit each) and pc (AW bits).

Function
REQ-010 SHALL run a stage FSM WAIT->FETCHA->FETCHB->EXECA->EXECB->FETCHA, with exactly one stage output high.
REQ-011 SHALL, in WAIT, go to FETCHA when run=1 and halt=0; halt=1 has priority over run.
REQ-012 SHALL, in FETCHA and FETCHB, drive mem_addr=pc and mem_rden=1, holding both until mem_ready=1 is sampled; on that edge it captures mem_rdata into IRA (FETCHA) or IRB (FETCHB), increments pc modulo 2^AW and advances the stage.
REQ-013 SHALL decode the opcode as IRA[7:5] class, IRA[4:3] sub, IRA[2:0] rd (index taken modulo NREG); any IRA bits above bit 7 are ignored.
REQ-014 SHALL execute LD (000/01): EXECA reads mem[IRB[AW-1:0]]; EXECB writes the read data to rd.
REQ-015 SHALL execute ST (000/10): EXECA writes rd to mem[IRB[AW-1:0]] with mem_wren=1, held until mem_ready=1.
REQ-016 SHALL execute jumps (class 001): JC=00, JNC=01, JZ=10, JMP=11; in EXECA it loads pc<=IRB[AW-1:0] when the condition holds, otherwise pc is unchanged.
REQ-017 SHALL execute LDI (010/xx): rd<=IRB in EXECB.
REQ-018 SHALL execute ALU ops (class 100): sub 00 ADD, 01 SUB, 10 AND, 11 OR; rd<=rd op r[IRB[2:0] mod NREG] in EXECB.
REQ-019 SHALL compute result and flags for ALU ops in EXECA: C = carry-out (ADD), borrow (SUB) or 0 (AND/OR); Z = (DW-bit result == 0); flags change only on ALU ops.
REQ-020 SHALL treat HLT (opcode 8'hFF) as entering WAIT after EXECB; all other encodings are NOPs.
REQ-021 SHALL keep mem_rden=mem_wren=0 in every stage and instruction not listed above; mem_rden and mem_wren are never high together.
REQ-022 SHALL, for each stage without a memory access, take exactly one cycle; an instruction with zero-wait memory takes 4 cycles.
REQ-023 SHALL sample halt on leaving EXECB and go to WAIT instead of FETCHA when it is high; an instruction in progress always completes.
REQ-024 SHALL drive mem_wdata = rd during ST and 0 otherwise.

Reset
REQ-025 SHALL, while rst=1, immediately force: stage WAIT (waits=1), pc=0, IRA=IRB=0, all registers=0, cflag=zflag=0, mem_rden=mem_wren=0, mem_addr=0.
REQ-026 SHALL abandon a pending memory access when reset asserts mid-access, with no retry after reset.

Configuration
REQ-027 SHALL, with MCPU_READY_EN defined, honour mem_ready wait states as in REQ-012/014/015.
REQ-028 SHALL, without MCPU_READY_EN, ignore mem_ready (treat it as 1), so every memory stage takes one cycle.

Structure
REQ-029 SHALL place the opcode class/sub encodings, the HLT value and the stage encoding in shared package mcpu_pkg.
REQ-030 SHALL place the register file in one sub-module, mcpu_regfile: parametrised DW/NREG, two asynchronous read ports, one write port, asynchronous reset.

Verification
REQ-031 SHALL cover: reset, run=1 with program LDI r1,5; LDI r2,3; ADD r1,r2; HLT -> r1=8, cflag=0, zflag=0, waits=1 after 16 cycles.
REQ-032 SHALL cover: DW=8, LDI r0,8'hFF; LDI r1,1; ADD r0,r1; JC 8'h40 -> r0=0, cflag=1, zflag=1, pc=8'h40.
REQ-033 SHALL cover: ST r3 (r3=8'hA5) to 8'h80, then LD r4 from 8'h80 -> mem[8'h80]=8'hA5, r4=8'hA5.
REQ-034 SHALL cover: with MCPU_READY_EN, mem_ready held low for 3 cycles in FETCHA -> mem_addr/mem_rden stable for those 3 cycles, pc unchanged until ready, instruction takes 7 cycles.
REQ-035 SHALL cover: halt=1 asserted during FETCHB -> instruction completes and the FSM enters WAIT; run=1 with halt=1 in WAIT -> remains in WAIT.
REQ-036 SHALL cover: rst pulsed during ST EXECA with mem_ready low -> mem_wren drops in the same cycle and all outputs return to reset values.
